// File: rtl/csr_trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_ctrl_pkg
// Description : Shared CSR addresses, mstatus bit positions and the state
//               encoding for the trap/MRET sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_trap_ctrl_pkg;

    // Write-port idle code; shares its value with the existing mdisable code
    localparam logic [11:0] CSR_NOP     = 12'hFFF;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_T_EPC    = 3'd1;
    localparam logic [2:0] S_T_CAUSE  = 3'd2;
    localparam logic [2:0] S_T_TVAL   = 3'd3;
    localparam logic [2:0] S_T_STATUS = 3'd4;
    localparam logic [2:0] S_T_JUMP   = 3'd5;
    localparam logic [2:0] S_R_STATUS = 3'd6;
    localparam logic [2:0] S_R_JUMP   = 3'd7;

endpackage : csr_trap_ctrl_pkg
`default_nettype wire

// File: rtl/csr_trap_vec.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_vec
// Description : Trap redirect target: direct base, or base + 4*cause for
//               interrupts when mtvec selects vectored mode.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_trap_vec #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_mtvec,
    input  logic            i_cause_int,
    input  logic [XLEN-3:0] i_cause_code,
    output logic [XLEN-1:0] o_target
);

    logic [XLEN-1:0] w_base;
    logic            w_vectored;

    assign w_base     = {i_mtvec[XLEN-1:2], 2'b00};
    // Modes 2'b10 and 2'b11 are reserved and fall back to direct
    assign w_vectored = (i_mtvec[1:0] == 2'b01) && i_cause_int;
    assign o_target   = w_vectored ? (w_base + {i_cause_code, 2'b00}) : w_base;

endmodule : csr_trap_vec
`default_nettype wire

// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_ctrl
// Description : Arbitrates the CSR write port between executrol writes and the
//               trap-entry / MRET sequences; emits a one-cycle PC redirect.
//               Optional mtval write enabled by CSR_TRAP_TVAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_csr_wen,
    input  logic [CSR_AW-1:0] exe_csr_waddr,
    input  logic [XLEN-1:0]   exe_csr_wdata,
    output logic              exe_ready_o,
    input  logic              trap_req,
    input  logic [XLEN-1:0]   trap_cause,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic [XLEN-1:0]   trap_tval,
    input  logic              mret_req,
    output logic              trap_ack_o,
    input  logic [XLEN-1:0]   mstatus_i,
    input  logic [XLEN-1:0]   mtvec_i,
    input  logic [XLEN-1:0]   mepc_i,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              busy_o,
    output logic              redirect_valid_o,
    output logic [XLEN-1:0]   redirect_pc_o
);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_cause;
    logic              r_pend_vld;
    logic [CSR_AW-1:0] r_pend_addr;
    logic [XLEN-1:0]   r_pend_data;
    logic              w_idle;
    logic              w_trap_acc;
    logic [XLEN-1:0]   w_mstatus_trap;
    logic [XLEN-1:0]   w_mstatus_mret;
    logic [XLEN-1:0]   w_vec_target;

    assign w_idle      = (r_state == S_IDLE);
    assign trap_ack_o  = w_idle & (trap_req | mret_req) & ~rst;
    assign exe_ready_o = w_idle & ~trap_req & ~mret_req & ~rst;
    assign w_trap_acc  = trap_ack_o & trap_req;

`ifdef CSR_TRAP_TVAL_EN
    logic [XLEN-1:0] r_tval;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tval <= '0;
        end else if (w_trap_acc) begin
            r_tval <= trap_tval;
        end
    end
`else
    logic w_unused_tval;
    assign w_unused_tval = ^trap_tval;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_cause <= '0;
        end else if (w_trap_acc) begin
            r_pc    <= trap_pc;
            r_cause <= trap_cause;
        end
    end

    // Pending slot lives exactly one cycle after acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else begin
            r_pend_vld <= exe_ready_o & exe_csr_wen;
            if (exe_ready_o & exe_csr_wen) begin
                r_pend_addr <= exe_csr_waddr;
                r_pend_data <= exe_csr_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (trap_req) begin
                    w_state_nxt = S_T_EPC;
                end else if (mret_req) begin
                    w_state_nxt = S_R_STATUS;
                end
            end
            S_T_EPC:    w_state_nxt = S_T_CAUSE;
`ifdef CSR_TRAP_TVAL_EN
            S_T_CAUSE:  w_state_nxt = S_T_TVAL;
            S_T_TVAL:   w_state_nxt = S_T_STATUS;
`else
            S_T_CAUSE:  w_state_nxt = S_T_STATUS;
`endif
            S_T_STATUS: w_state_nxt = S_T_JUMP;
            S_T_JUMP:   w_state_nxt = S_IDLE;
            S_R_STATUS: w_state_nxt = S_R_JUMP;
            S_R_JUMP:   w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mstatus_trap = mstatus_i;
        w_mstatus_trap[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
        w_mstatus_trap[MSTATUS_MIE]  = 1'b0;
        w_mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_comb begin
        w_mstatus_mret = mstatus_i;
        w_mstatus_mret[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
        w_mstatus_mret[MSTATUS_MPIE] = 1'b1;
        w_mstatus_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    csr_trap_vec #(
        .XLEN (XLEN)
    ) u_vec (
        .i_mtvec      (mtvec_i),
        .i_cause_int  (r_cause[XLEN-1]),
        .i_cause_code (r_cause[XLEN-3:0]),
        .o_target     (w_vec_target)
    );

    always_comb begin
        csr_waddr_o      = CSR_AW'(CSR_NOP);
        csr_wdata_o      = '0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        busy_o           = ~w_idle;
        case (r_state)
            S_IDLE: begin
                if (r_pend_vld) begin
                    csr_waddr_o = r_pend_addr;
                    csr_wdata_o = r_pend_data;
                end
            end
            S_T_EPC: begin
                csr_waddr_o = CSR_AW'(CSR_MEPC);
                csr_wdata_o = {r_pc[XLEN-1:2], 2'b00};
            end
            S_T_CAUSE: begin
                csr_waddr_o = CSR_AW'(CSR_MCAUSE);
                csr_wdata_o = r_cause;
            end
`ifdef CSR_TRAP_TVAL_EN
            S_T_TVAL: begin
                csr_waddr_o = CSR_AW'(CSR_MTVAL);
                csr_wdata_o = r_tval;
            end
`endif
            S_T_STATUS: begin
                csr_waddr_o = CSR_AW'(CSR_MSTATUS);
                csr_wdata_o = w_mstatus_trap;
            end
            S_T_JUMP: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = w_vec_target;
            end
            S_R_STATUS: begin
                csr_waddr_o = CSR_AW'(CSR_MSTATUS);
                csr_wdata_o = w_mstatus_mret;
            end
            S_R_JUMP: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = mepc_i;
            end
            default: ;
        endcase
    end

endmodule : csr_trap_ctrl
`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_trap_ctrl
// Description : Self-checking bench: directed test-plan steps then random
//               traffic, compared cycle by cycle against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_trap_ctrl;
    import csr_trap_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        exe_csr_wen;
    logic [11:0] exe_csr_waddr;
    logic [31:0] exe_csr_wdata;
    logic        exe_ready_o;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret_req;
    logic        trap_ack_o;
    logic [31:0] mstatus_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        busy_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    csr_trap_ctrl #(.XLEN(32), .CSR_AW(12)) dut (
        .clk              (clk),
        .rst              (rst),
        .exe_csr_wen      (exe_csr_wen),
        .exe_csr_waddr    (exe_csr_waddr),
        .exe_csr_wdata    (exe_csr_wdata),
        .exe_ready_o      (exe_ready_o),
        .trap_req         (trap_req),
        .trap_cause       (trap_cause),
        .trap_pc          (trap_pc),
        .trap_tval        (trap_tval),
        .mret_req         (mret_req),
        .trap_ack_o       (trap_ack_o),
        .mstatus_i        (mstatus_i),
        .mtvec_i          (mtvec_i),
        .mepc_i           (mepc_i),
        .csr_waddr_o      (csr_waddr_o),
        .csr_wdata_o      (csr_wdata_o),
        .busy_o           (busy_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
        logic        rv;
        logic [31:0] pc;
    } ent_t;

    // Expected per-cycle port activity of an in-flight sequence
    ent_t        q[$];
    logic        m_pend_v = 1'b0;
    logic [11:0] m_pend_a = '0;
    logic [31:0] m_pend_d = '0;
    logic        m_mret_acc = 1'b0;
    logic        prev_rv = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [11:0] a, input logic [31:0] d, input logic rv, input logic [31:0] pc);
        ent_t e;
        e.a = a; e.d = d; e.rv = rv; e.pc = pc;
        q.push_back(e);
    endtask

    task automatic push_trap();
        logic [31:0] tgt;
        push(CSR_MEPC, trap_pc & ~32'h3, 1'b0, 32'h0);
        push(CSR_MCAUSE, trap_cause, 1'b0, 32'h0);
`ifdef CSR_TRAP_TVAL_EN
        push(CSR_MTVAL, trap_tval, 1'b0, 32'h0);
`endif
        push(CSR_MSTATUS, (mstatus_i & ~32'h88) | (((mstatus_i >> 3) & 32'h1) << 7) | 32'h1800,
             1'b0, 32'h0);
        tgt = mtvec_i & ~32'h3;
        if ((mtvec_i & 32'h3) == 32'h1 && trap_cause >= 32'h8000_0000)
            tgt = tgt + (trap_cause << 2);
        push(CSR_NOP, 32'h0, 1'b1, tgt);
    endtask

    task automatic push_mret();
        push(CSR_MSTATUS, (mstatus_i & ~32'h88) | (((mstatus_i >> 7) & 32'h1) << 3) | 32'h1880,
             1'b0, 32'h0);
        push(CSR_NOP, 32'h0, 1'b1, mepc_i);
    endtask

    // Called at posedge+1 with inputs set; checks outputs, then advances one edge
    task automatic step();
        ent_t e;
        logic busy, ack, rdy;
        #3;
        busy = (q.size() != 0);
        ack  = !rst && !busy && (trap_req || mret_req);
        rdy  = !rst && !busy && !trap_req && !mret_req;
        e.a = CSR_NOP; e.d = 32'h0; e.rv = 1'b0; e.pc = 32'h0;
        if (busy) e = q[0];
        else if (m_pend_v) begin e.a = m_pend_a; e.d = m_pend_d; end
        chk("waddr", 32'(csr_waddr_o), 32'(e.a));
        chk("wdata", csr_wdata_o, e.d);
        chk("redir_valid", 32'(redirect_valid_o), 32'(e.rv));
        chk("redir_pc", redirect_pc_o, e.pc);
        chk("busy", 32'(busy_o), 32'(busy));
        chk("trap_ack", 32'(trap_ack_o), 32'(ack));
        chk("exe_ready", 32'(exe_ready_o), 32'(rdy));
        chk("redir_once", 32'(prev_rv & redirect_valid_o), 32'h0);
        prev_rv = redirect_valid_o;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_pend_v = 1'b0;
        end else begin
            if (busy) q.delete(0);
            m_pend_v = rdy && exe_csr_wen;
            m_pend_a = exe_csr_waddr;
            m_pend_d = exe_csr_wdata;
            if (ack && trap_req) push_trap();
            else if (ack) begin push_mret(); m_mret_acc = 1'b1; end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; exe_csr_wen = 1'b0; exe_csr_waddr = '0; exe_csr_wdata = '0;
        trap_req = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0; mret_req = 1'b0;
        mstatus_i = '0; mtvec_i = '0; mepc_i = '0;
        @(posedge clk); #1;
        step();
        chk("reset_waddr", 32'(csr_waddr_o), 32'(CSR_NOP));
        rst = 1'b0;
        step();

        // Plain exe write
        exe_csr_wen = 1'b1; exe_csr_waddr = 12'h340; exe_csr_wdata = 32'hDEAD_BEEF;
        step();
        exe_csr_wen = 1'b0;
        #3;
        chk("exe_waddr_lit", 32'(csr_waddr_o), 32'h340);
        chk("exe_wdata_lit", csr_wdata_o, 32'hDEAD_BEEF);
        #(-0);
        @(posedge clk); #1;
        m_pend_v = 1'b0;
        step();

        // Exception, direct mode
        mstatus_i = 32'h8; mtvec_i = 32'h400;
        trap_req = 1'b1; trap_cause = 32'h2; trap_pc = 32'h1006; trap_tval = 32'hBAD0;
        step();
        trap_req = 1'b0;
        repeat (6) step();

        // Interrupt, vectored mode
        mtvec_i = 32'h401; trap_req = 1'b1; trap_cause = 32'h8000_0007;
        step();
        trap_req = 1'b0;
        repeat (6) step();

        // MRET
        mstatus_i = 32'h1880; mepc_i = 32'h2000; mret_req = 1'b1;
        step();
        mret_req = 1'b0;
        repeat (3) step();

        // All three requests together; MRET held until taken
        mstatus_i = 32'h8; mtvec_i = 32'h400; m_mret_acc = 1'b0;
        trap_req = 1'b1; mret_req = 1'b1; exe_csr_wen = 1'b1; trap_cause = 32'hB;
        step();
        trap_req = 1'b0; exe_csr_wen = 1'b0;
        for (int i = 0; i < 12 && !m_mret_acc; i++) step();
        chk("mret_taken", 32'(m_mret_acc), 32'h1);
        mret_req = 1'b0;
        repeat (3) step();

        // Pending exe write overlapping a new trap
        exe_csr_wen = 1'b1; exe_csr_waddr = 12'h305; exe_csr_wdata = 32'h1234_5678;
        step();
        exe_csr_wen = 1'b0; trap_req = 1'b1; trap_cause = 32'h5;
        step();
        trap_req = 1'b0;
        repeat (6) step();

        // Reset during T_CAUSE
        trap_req = 1'b1;
        step();
        trap_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        repeat (3) step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (q.size() == 0) begin
                mstatus_i = $urandom;
                mtvec_i   = $urandom;
                mepc_i    = $urandom;
            end
            rst           = ($urandom_range(0, 63) == 0);
            trap_req      = ($urandom_range(0, 7) == 0);
            mret_req      = ($urandom_range(0, 7) == 0);
            exe_csr_wen   = $urandom_range(0, 1) == 1;
            exe_csr_waddr = 12'($urandom);
            exe_csr_wdata = $urandom;
            trap_cause    = {1'($urandom), 26'h0, 5'($urandom)};
            trap_pc       = $urandom;
            trap_tval     = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_csr_trap_ctrl
`default_nettype wire

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Trap and MRET sequencer for the single write port of the CSR register file. It arbitrates that port between ordinary CSR-instruction writes from executrol and the multi-cycle trap-entry / trap-return sequences. It performs the architectural mstatus/mepc/mcause updates and emits a one-cycle PC redirect to fetch. It sits between executrol, the trap sources (id/executrol exceptions, interrupt logic) and the CSR file.

## Interface
Parameters:
- XLEN, 32, data width
- CSR_AW, 12, CSR address width

Ports:
- Reset: rst, synchronous, active-high. Clock: clk.
- clk  in  1  clock
- rst  in  1  reset
- exe_csr_wen  in  1  executrol CSR write request
- exe_csr_waddr  in  CSR_AW  executrol CSR write address
- exe_csr_wdata  in  XLEN  executrol CSR write data
- exe_ready_o  out  1  executrol write accepted this cycle
- trap_req  in  1  trap request, level, held until accepted
- trap_cause  in  XLEN  mcause value; bit 31 = interrupt
- trap_pc  in  XLEN  faulting/interrupted PC
- trap_tval  in  XLEN  mtval value
- mret_req  in  1  MRET request
- trap_ack_o  out  1  trap or MRET accepted this cycle
- mstatus_i, mtvec_i, mepc_i  in  XLEN  current CSR values from CSR file read side
- csr_waddr_o  out  CSR_AW  CSR file write address; CSR_NOP when idle
- csr_wdata_o  out  XLEN  CSR file write data
- busy_o  out  1  sequence in progress
- redirect_valid_o  out  1  one-cycle PC redirect strobe
- redirect_pc_o  out  XLEN  redirect target

## Operation
- States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_JUMP, R_STATUS, R_JUMP. Moore outputs decoded from registered state and latches.
- Priority in IDLE: trap_req > mret_req > exe_csr_wen.
- exe_ready_o = (state==IDLE) & !trap_req & !mret_req.
- trap_ack_o = (state==IDLE) & (trap_req | mret_req).
- Trap accept: latch trap_pc, trap_cause, trap_tval. Then IDLE→T_EPC→T_CAUSE→(T_TVAL)→T_STATUS→T_JUMP→IDLE.
- Trap state writes:
  - T_EPC: mepc (0x341) ← pc & ~3.
  - T_CAUSE: mcause (0x342) ← cause.
  - T_TVAL: mtval (0x343) ← tval.
  - T_STATUS: mstatus (0x300) ← mstatus_i with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11.
- T_JUMP: csr_waddr_o=CSR_NOP, redirect_valid_o=1.
  - redirect_pc_o = {mtvec_i[31:2],2'b00}, plus {cause[29:0],2'b00} when mtvec_i[1:0]==2'b01 and cause[31]==1.
  - mtvec_i[1:0] of 2'b10 or 2'b11 is treated as direct.
- MRET accept: IDLE→R_STATUS→R_JUMP→IDLE.
  - R_STATUS: mstatus ← mstatus_i with MIE=MPIE, MPIE=1, MPP=2'b11.
  - R_JUMP: redirect_valid_o=1, redirect_pc_o=mepc_i.
- Accepted exe write: registered into a pending slot and presented on csr_waddr_o/csr_wdata_o for exactly the next cycle. The ack/trap decision is unaffected by the slot.
- Outputs when no write is presented: csr_waddr_o = CSR_NOP, csr_wdata_o = 0, redirect_pc_o = 0.
- busy_o = (state != IDLE).

## Timing
- Reset values: all outputs 0 except csr_waddr_o=CSR_NOP. State IDLE, pending slot empty.
- Reset mid-sequence aborts: no further writes, no redirect.
- Exe write latency: accepted at edge N, visible on port during cycle N+1.
- Trap latency, accept at edge 0:
  - mepc write in cycle 1, mcause in cycle 2.
  - With TVAL: mtval in cycle 3, mstatus in cycle 4, redirect in cycle 5.
  - Without TVAL: mstatus in cycle 3, redirect in cycle 4.
- MRET latency: mstatus write in cycle 1, redirect in cycle 2.
- Trap and mret_req in the same cycle: trap accepted; mret_req must be held by the requester.
- Pending exe write and new trap in the same cycle: exe write still issues this cycle; T_EPC follows.
- Requests arriving while busy are ignored; requesters hold.
- redirect_valid_o is never high for more than one consecutive cycle.

## Configuration
- CSR_TRAP_TVAL_EN defined: T_TVAL state present and mtval written.
- Undefined: T_TVAL removed, trap_tval unused, T_CAUSE→T_STATUS directly.

## Structure
- Shared package/defines hold:
  - CSR_NOP, equal to the existing `mdisable` code.
  - CSR addresses for mstatus, mtvec, mepc, mcause, mtval.
  - mstatus bit positions MIE=3, MPIE=7, MPP=12:11.
  - State encoding.
- One sub-module, csr_trap_vec: combinational redirect target computation (direct/vectored).

## Test plan
- Exe write 0x340←0xDEADBEEF in IDLE → exe_ready_o=1; next cycle csr_waddr_o=0x340, csr_wdata_o=0xDEADBEEF; then CSR_NOP.
- Trap with cause=2, pc=0x1006, mstatus_i=0x8, mtvec_i=0x400 (TVAL off) → writes mepc=0x1004, mcause=2, mstatus=0x1880; redirect 0x400 in cycle 4.
- Interrupt with cause=0x80000007, mtvec_i=0x401 → redirect_pc_o=0x41C; with TVAL on, mtval written in cycle 3 and redirect in cycle 5.
- MRET with mstatus_i=0x1880, mepc_i=0x2000 → mstatus write 0x1888 in cycle 1; redirect 0x2000 in cycle 2.
- trap_req, mret_req and exe_csr_wen all high in IDLE → trap_ack_o=1, exe_ready_o=0, trap sequence runs; MRET runs after return to IDLE.
- rst asserted during T_CAUSE → next cycle csr_waddr_o=CSR_NOP, busy_o=0, no redirect.
